// File: rtl/product_display.sv
// Product display: converts the multiplier's 8-bit product (AQ) to BCD with a
// double-dabble engine and scans it onto a 3-digit common-anode 7-segment display.
// Optional macro PRODUCT_DISPLAY_BLANK_EN enables leading-zero blanking.
module product_display #(
   parameter int SCAN_DIV  = 1024,
   parameter int CONV_BITS = 8
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       load,
   input  logic [7:0] value,
   output logic       busy,
   output logic [6:0] seg,
   output logic [2:0] dig_en
);

   generate
      if (CONV_BITS != 8) begin : g_conv_bits_check
         $error("product_display: CONV_BITS must be 8");
      end
      if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_scan_div_check
         $error("product_display: SCAN_DIV must be in 2..65535");
      end
   endgenerate

   localparam logic [1:0]  IDLE      = 2'd0;
   localparam logic [1:0]  CONV      = 2'd1;
   localparam logic [1:0]  UPDATE    = 2'd2;
   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;

   logic [1:0]  state;
   logic [7:0]  shift_reg;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  bit_cnt;
   logic [3:0]  disp_hund;
   logic [3:0]  disp_tens;
   logic [3:0]  disp_units;
   logic [15:0] scan_cnt;
   logic [1:0]  digit_idx;
   logic [1:0]  next_idx;
   logic [3:0]  cur_digit;
   logic        blank;

   function automatic logic [3:0] adjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   assign bcd_adj = {adjust(bcd[11:8]), adjust(bcd[7:4]), adjust(bcd[3:0])};
   assign busy    = (state != IDLE);

   // Conversion engine; the display registers only change in UPDATE, so the
   // scan never shows a partially converted value.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= IDLE;
         shift_reg  <= 8'd0;
         bcd        <= 12'd0;
         bit_cnt    <= 3'd0;
         disp_hund  <= 4'd0;
         disp_tens  <= 4'd0;
         disp_units <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  shift_reg <= value;
                  bcd       <= 12'd0;
                  bit_cnt   <= 3'd0;
                  state     <= CONV;
               end
            end
            CONV: begin
               {bcd, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
               bit_cnt          <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               disp_hund  <= bcd[11:8];
               disp_tens  <= bcd[7:4];
               disp_units <= bcd[3:0];
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      next_idx = digit_idx;
      if (scan_cnt == SCAN_LAST) begin
         next_idx = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end
   end

   always_comb begin
      case (next_idx)
         2'd1:    cur_digit = disp_tens;
         2'd2:    cur_digit = disp_hund;
         default: cur_digit = disp_units;
      endcase
   end

   // Leading zeros: hundreds blanks on 0, tens only when hundreds is also 0.
   always_comb begin
      blank = 1'b0;
`ifdef PRODUCT_DISPLAY_BLANK_EN
      case (next_idx)
         2'd1:    blank = (disp_tens == 4'd0) && (disp_hund == 4'd0);
         2'd2:    blank = (disp_hund == 4'd0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
   end

   // seg and dig_en are both derived from next_idx so they switch on the same edge.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         scan_cnt  <= 16'd0;
         digit_idx <= 2'd0;
         seg       <= 7'b1000000;
         dig_en    <= 3'b110;
      end else begin
         scan_cnt  <= (scan_cnt == SCAN_LAST) ? 16'd0 : scan_cnt + 16'd1;
         digit_idx <= next_idx;
         seg       <= blank ? SEG_BLANK : glyph(cur_digit);
         case (next_idx)
            2'd1:    dig_en <= 3'b101;
            2'd2:    dig_en <= 3'b011;
            default: dig_en <= 3'b110;
         endcase
      end
   end

endmodule

// File: tb/tb_product_display.sv
// Testbench for product_display: decimal-level reference model checked every
// cycle, plus directed vectors with hand-computed segment patterns.
module tb_product_display;

   localparam int SCAN_DIV = 4;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] BL = 7'b1111111;

   localparam logic [6:0] GLYPH [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   localparam logic [2:0] SCAN_SEQ [15] = '{
      3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101,
      3'b011, 3'b011, 3'b011, 3'b011, 3'b110, 3'b110, 3'b110, 3'b110};

`ifdef PRODUCT_DISPLAY_BLANK_EN
   localparam logic [6:0] LEAD0 = BL;
`else
   localparam logic [6:0] LEAD0 = G0;
`endif

   logic       clk;
   logic       n_reset;
   logic       load;
   logic [7:0] value;
   logic       busy;
   logic [6:0] seg;
   logic [2:0] dig_en;

   int  checks   = 0;
   int  failures = 0;
   bit  compare_en = 1'b0;

   // Reference model state: edges since reset, remaining busy cycles, shown value.
   int  k         = 0;
   int  left      = 0;
   int  disp      = 0;
   int  prev_disp = 0;
   int  pending   = 0;

   product_display #(.SCAN_DIV(SCAN_DIV), .CONV_BITS(8)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .load    (load),
      .value   (value),
      .busy    (busy),
      .seg     (seg),
      .dig_en  (dig_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         k         <= 0;
         left      <= 0;
         disp      <= 0;
         prev_disp <= 0;
      end else begin
         k         <= k + 1;
         prev_disp <= disp;
         if (left > 0) begin
            left <= left - 1;
            if (left == 1) disp <= pending;
         end else if (load) begin
            left    <= 9;
            pending <= int'(value);
         end
      end
   end

   function automatic logic [6:0] expSeg(input int v, input int idx);
      int h, t, u;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      if (idx == 0) return GLYPH[u];
`ifdef PRODUCT_DISPLAY_BLANK_EN
      if (idx == 1) return (t == 0 && h == 0) ? BL : GLYPH[t];
      return (h == 0) ? BL : GLYPH[h];
`else
      if (idx == 1) return GLYPH[t];
      return GLYPH[h];
`endif
   endfunction

   function automatic logic [2:0] expDigEn(input int idx);
      if (idx == 0) return 3'b110;
      if (idx == 1) return 3'b101;
      return 3'b011;
   endfunction

   task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (compare_en) begin
         checkOutput("model_busy", {6'd0, busy}, {6'd0, (left > 0)});
         checkOutput("model_dig_en", {4'd0, dig_en}, {4'd0, expDigEn((k / SCAN_DIV) % 3)});
         checkOutput("model_seg", seg, expSeg(prev_disp, (k / SCAN_DIV) % 3));
      end
   end

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idle_timeout", {6'd0, busy}, 7'd0);
   endtask

   // Issue one load; optionally change value late and pulse a second load mid-conversion.
   task automatic applyStimulus(input logic [7:0] v, input logic [7:0] late_v,
                                input int pulse_at, input logic [7:0] pulse_v);
      int count;
      waitIdle();
      @(negedge clk);
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
      value = late_v;
      count = 0;
      while (busy && count < 30) begin
         count++;
         load = (count == pulse_at);
         if (count == pulse_at) value = pulse_v;
         @(negedge clk);
      end
      load = 1'b0;
      checkOutput("busy_len", 7'(count), 7'd9);
      @(negedge clk);
   endtask

   task automatic checkSlot(input string name, input logic [2:0] pat, input logic [6:0] exp_seg);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (dig_en == pat) found = 1'b1;
      end
      if (found) checkOutput(name, seg, exp_seg);
      else checkOutput({name, "_timeout"}, {4'd0, dig_en}, {4'd0, pat});
   endtask

   task automatic checkDisplay(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
      checkSlot("units", 3'b110, u);
      checkSlot("tens", 3'b101, t);
      checkSlot("hundreds", 3'b011, h);
   endtask

   initial begin
      n_reset = 1'b1;
      load    = 1'b0;
      value   = 8'd0;
      #1 n_reset = 1'b0;
      #1 compare_en = 1'b1;
      @(negedge clk);
      checkOutput("reset_busy", {6'd0, busy}, 7'd0);
      checkOutput("reset_dig_en", {4'd0, dig_en}, 7'b0000110);
      checkOutput("reset_seg", seg, G0);
      @(negedge clk);
      n_reset = 1'b1;
      $display("[TB] free-running scan sequence");
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         checkOutput("scan_seq", {4'd0, dig_en}, {4'd0, SCAN_SEQ[i - 1]});
      end

      $display("[TB] convert 35");
      applyStimulus(8'd35, 8'd35, 0, 8'd0);
      checkDisplay(G5, G3, LEAD0);

      $display("[TB] convert 255 and 0");
      applyStimulus(8'd255, 8'd255, 0, 8'd0);
      checkDisplay(G5, G5, G2);
      applyStimulus(8'd0, 8'd0, 0, 8'd0);
      checkDisplay(G0, LEAD0, LEAD0);

      $display("[TB] load while busy is ignored");
      applyStimulus(8'd35, 8'd35, 3, 8'd99);
      checkDisplay(G5, G3, LEAD0);

      $display("[TB] value changes after accepted load");
      applyStimulus(8'd0, 8'd0, 0, 8'd0);
      applyStimulus(8'd35, 8'd200, 0, 8'd0);
      checkDisplay(G5, G3, LEAD0);

      $display("[TB] reset during conversion of 200");
      waitIdle();
      @(negedge clk);
      load  = 1'b1;
      value = 8'd200;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("busy_mid", {6'd0, busy}, 7'd1);
      #2 n_reset = 1'b0;
      #1;
      checkOutput("rst_busy", {6'd0, busy}, 7'd0);
      checkOutput("rst_dig_en", {4'd0, dig_en}, 7'b0000110);
      checkOutput("rst_seg", seg, G0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      repeat (15) @(negedge clk);
      checkDisplay(G0, LEAD0, LEAD0);

      repeat (4) @(negedge clk);
      compare_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d failures %0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
